mem_arb: RTL and testbench

Byte-serial memory controller and arbiter sharing the single 8-bit RAM port between instruction fetch (IF) and the load/store path (MEM). Accepts one 32-bit IF fetch or one 1/2/4-byte MEM access at a time and sequences it as consecutive byte cycles. Assembles little-endian read data with sign/zero extension and returns a one-cycle ack to the granted requester. Sits between IF, the MEM stage (fed by EX's 5-bit `ex_mem_e` code) and the RAM.

---
 rtl/mem_arb_if.sv | 31 +++
 rtl/mem_arb.sv | 180 ++++++++++++++++++
 tb/tb_mem_arb.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_if.sv
// mem_arb_if: request, response and RAM-side signals of the byte-serial memory arbiter.
// slave = the arbiter itself, master = the IF/MEM requesters plus the RAM.
interface mem_arb_if #(
    parameter int ADDR_W = 17
);
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_flush;
    logic              if_ack;
    logic [31:0]       if_data;
    logic [4:0]        mem_e;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;
    logic [ADDR_W-1:0] ram_a;
    logic [7:0]        ram_dout;
    logic              ram_wr;
    logic [7:0]        ram_din;
    logic              busy;

    modport slave (
        input  if_req, if_addr, if_flush, mem_e, mem_addr, mem_wdata, ram_din,
        output if_ack, if_data, mem_ack, mem_rdata, ram_a, ram_dout, ram_wr, busy
    );

    modport master (
        output if_req, if_addr, if_flush, mem_e, mem_addr, mem_wdata, ram_din,
        input  if_ack, if_data, mem_ack, mem_rdata, ram_a, ram_dout, ram_wr, busy
    );
endinterface

// File: rtl/mem_arb.sv
// mem_arb: byte-serial controller sharing one 8-bit RAM port between fetch and load/store.
// Optional MEM_ARB_RR_EN: round-robin tie-break instead of fixed MEM-over-IF priority.
module mem_arb #(
    parameter int ADDR_W = 17
) (
    input  logic     clk,
    input  logic     rst,
    mem_arb_if.slave bus
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [2:0]        len_q, len_d;
    logic              is_if_q, is_if_d;
    logic              sign_q, sign_d;
    logic [31:0]       base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       buf_q, buf_d;
    logic [ADDR_W-1:0] ram_a_q, ram_a_d;
    logic [7:0]        ram_dout_q, ram_dout_d;
    logic              ram_wr_q, ram_wr_d;
    logic              if_ack_q, if_ack_d;
    logic              mem_ack_q, mem_ack_d;
    logic [31:0]       if_data_q, if_data_d;
    logic [31:0]       mem_rdata_q, mem_rdata_d;
    logic              busy_q, busy_d;

    logic              mem_req, if_req_ok, accept_ok, grant_mem, grant_if;
    logic [2:0]        lane;
    logic [31:0]       ext;

    assign mem_req   = bus.mem_e[4];
    assign if_req_ok = bus.if_req && !bus.if_flush;
    // The ack cycle is already IDLE; skipping it lets a requester drop req on seeing its ack.
    assign accept_ok = (state_q == IDLE) && !if_ack_q && !mem_ack_q;

`ifdef MEM_ARB_RR_EN
    logic last_mem_q;

    assign grant_mem = accept_ok && mem_req && !(if_req_ok && last_mem_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                        last_mem_q <= 1'b0;
        else if (grant_mem || grant_if)  last_mem_q <= grant_mem;
    end
`else
    assign grant_mem = accept_ok && mem_req;
`endif
    assign grant_if = accept_ok && if_req_ok && !grant_mem;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (grant_if || (grant_mem && !bus.mem_e[1])) state_d = READ;
                   else if (grant_mem)                          state_d = WRITE;
            READ:  if (is_if_q && bus.if_flush)                 state_d = IDLE;
                   else if (idx_q == len_q)                     state_d = DONE;
            WRITE: if (idx_q == len_q - 3'd1)                   state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign lane = idx_q - 3'd1;

    always_comb begin
        ext = buf_q;
        if (len_q == 3'd1)      ext = {{24{sign_q & buf_q[7]}}, buf_q[7:0]};
        else if (len_q == 3'd2) ext = {{16{sign_q & buf_q[15]}}, buf_q[15:0]};
    end

    always_comb begin
        idx_d       = idx_q;
        len_d       = len_q;
        is_if_d     = is_if_q;
        sign_d      = sign_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        buf_d       = buf_q;
        ram_a_d     = ram_a_q;
        ram_dout_d  = ram_dout_q;
        ram_wr_d    = 1'b0;
        if_ack_d    = 1'b0;
        mem_ack_d   = 1'b0;
        if_data_d   = if_data_q;
        mem_rdata_d = mem_rdata_q;
        busy_d      = (state_d != IDLE);
        unique case (state_q)
            IDLE: if (grant_if || grant_mem) begin
                idx_d   = 3'd0;
                buf_d   = 32'd0;
                is_if_d = grant_if;
                if (grant_if) begin
                    base_d = bus.if_addr;
                    len_d  = 3'd4;
                    sign_d = 1'b0;
                end else begin
                    base_d  = bus.mem_addr;
                    len_d   = {1'b0, bus.mem_e[3:2]} + 3'd1;
                    sign_d  = bus.mem_e[0];
                    wdata_d = bus.mem_wdata;
                end
            end
            READ: begin
                if (idx_q < len_q) ram_a_d = ADDR_W'(base_q + 32'(idx_q));
                if (idx_q != 3'd0) buf_d[{lane[1:0], 3'b000} +: 8] = bus.ram_din;
                idx_d = idx_q + 3'd1;
            end
            WRITE: begin
                ram_wr_d   = 1'b1;
                ram_a_d    = ADDR_W'(base_q + 32'(idx_q));
                ram_dout_d = wdata_q[{idx_q[1:0], 3'b000} +: 8];
                idx_d      = idx_q + 3'd1;
            end
            DONE: begin
                if (is_if_q) begin
                    if (!bus.if_flush) begin
                        if_ack_d  = 1'b1;
                        if_data_d = buf_q;
                    end
                end else begin
                    mem_ack_d   = 1'b1;
                    mem_rdata_d = ext;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idx_q       <= 3'd0;
            len_q       <= 3'd0;
            is_if_q     <= 1'b0;
            sign_q      <= 1'b0;
            base_q      <= 32'd0;
            wdata_q     <= 32'd0;
            buf_q       <= 32'd0;
            ram_a_q     <= '0;
            ram_dout_q  <= 8'd0;
            ram_wr_q    <= 1'b0;
            if_ack_q    <= 1'b0;
            mem_ack_q   <= 1'b0;
            if_data_q   <= 32'd0;
            mem_rdata_q <= 32'd0;
            busy_q      <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            len_q       <= len_d;
            is_if_q     <= is_if_d;
            sign_q      <= sign_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            buf_q       <= buf_d;
            ram_a_q     <= ram_a_d;
            ram_dout_q  <= ram_dout_d;
            ram_wr_q    <= ram_wr_d;
            if_ack_q    <= if_ack_d;
            mem_ack_q   <= mem_ack_d;
            if_data_q   <= if_data_d;
            mem_rdata_q <= mem_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.ram_a     = ram_a_q;
    assign bus.ram_dout  = ram_dout_q;
    assign bus.ram_wr    = ram_wr_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.if_data   = if_data_q;
    assign bus.mem_ack   = mem_ack_q;
    assign bus.mem_rdata = mem_rdata_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: self-checking bench for mem_arb with a byte RAM model and an ack scoreboard.
// Expected collision order follows MEM_ARB_RR_EN when it is defined for the build.
module tb_mem_arb;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    mem_arb_if #(.ADDR_W(17)) bus ();
    mem_arb #(.ADDR_W(17)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    logic [7:0]  ram [0:(1<<17)-1];
    assign bus.ram_din = ram[bus.ram_a];

    // bit 32 = expected requester is IF, bits 31:0 = expected data
    logic [32:0] sb [$];

    logic [16:0] tr_a   [0:31];
    logic        tr_wr  [0:31];
    logic [7:0]  tr_d   [0:31];
    logic        tr_ack [0:31];

    task automatic apply_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Drives one request, records the bus per cycle after the accept edge, returns ack latency.
    task automatic issue(input bit is_if, input logic [31:0] addr, input logic [4:0] e,
                         input logic [31:0] wd, output int lat, output logic [31:0] data);
        bit got;
        repeat (2) @(negedge clk);
        if (is_if) begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end else begin
            bus.mem_e = e; bus.mem_addr = addr; bus.mem_wdata = wd;
        end
        @(posedge clk);
        lat  = -1;
        data = 32'd0;
        for (int k = 0; k < 32; k++) begin
            tr_a[k] = 17'd0; tr_wr[k] = 1'b0; tr_d[k] = 8'd0; tr_ack[k] = 1'b0;
        end
        for (int k = 1; k < 30; k++) begin
            @(posedge clk); #1;
            got       = is_if ? bus.if_ack : bus.mem_ack;
            tr_a[k]   = bus.ram_a;
            tr_wr[k]  = bus.ram_wr;
            tr_d[k]   = bus.ram_dout;
            tr_ack[k] = got;
            if (got && lat < 0) begin
                lat  = k;
                data = is_if ? bus.if_data : bus.mem_rdata;
                bus.if_req = 1'b0;
                bus.mem_e  = 5'd0;
            end
            if (lat >= 0 && k >= lat + 2) break;
        end
        bus.if_req = 1'b0;
        bus.mem_e  = 5'd0;
    endtask

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        total++; if (bus.busy !== 1'b0)    begin bad++; $display("FAIL rst_busy got=%0b want=0", bus.busy); end
        total++; if (bus.ram_wr !== 1'b0)  begin bad++; $display("FAIL rst_ram_wr got=%0b want=0", bus.ram_wr); end
        total++; if (bus.ram_a !== 17'd0)  begin bad++; $display("FAIL rst_ram_a got=%h want=0", bus.ram_a); end
        total++; if (bus.if_ack !== 1'b0 || bus.mem_ack !== 1'b0)
            begin bad++; $display("FAIL rst_acks got=%0b%0b want=00", bus.if_ack, bus.mem_ack); end
        apply_reset();
    endtask

    task automatic test_fetch();
        int lat; logic [31:0] d; logic [32:0] e;
        ram[17'h100] = 8'h13; ram[17'h101] = 8'h05; ram[17'h102] = 8'hA0; ram[17'h103] = 8'h00;
        sb.push_back({1'b1, 32'h00A00513});
        issue(1'b1, 32'h100, 5'd0, 32'd0, lat, d);
        for (int k = 1; k <= 4; k++) begin
            total++;
            if (tr_a[k] !== 17'h100 + 17'(k - 1))
                begin bad++; $display("FAIL fetch_addr cyc=%0d got=%h want=%h", k, tr_a[k], 17'h100 + 17'(k - 1)); end
        end
        total++; if (lat !== 6) begin bad++; $display("FAIL fetch_latency got=%0d want=6", lat); end
        e = sb.pop_front();
        total++; if (d !== e[31:0]) begin bad++; $display("FAIL fetch_data got=%h want=%h", d, e[31:0]); end
        total++; if (tr_ack[lat + 1] !== 1'b0) begin bad++; $display("FAIL fetch_ack_width got=%0b want=0", tr_ack[lat + 1]); end
    endtask

    task automatic test_loads();
        logic [31:0] addrs [5] = '{32'h20, 32'h20, 32'h20, 32'h20, 32'h100};
        logic [4:0]  codes [5] = '{5'h11, 5'h10, 5'h15, 5'h14, 5'h1C};
        logic [31:0] exps  [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFFFF80, 32'h0000FF80, 32'h00A00513};
        int          lats  [5] = '{3, 3, 4, 4, 6};
        int lat; logic [31:0] d; logic [32:0] e;
        ram[17'h20] = 8'h80; ram[17'h21] = 8'hFF;
        for (int i = 0; i < 5; i++) begin
            sb.push_back({1'b0, exps[i]});
            issue(1'b0, addrs[i], codes[i], 32'd0, lat, d);
            e = sb.pop_front();
            total++; if (d !== e[31:0]) begin bad++; $display("FAIL load%0d_data got=%h want=%h", i, d, e[31:0]); end
            total++; if (lat !== lats[i]) begin bad++; $display("FAIL load%0d_latency got=%0d want=%0d", i, lat, lats[i]); end
        end
    endtask

    task automatic test_store();
        logic [31:0] wd = 32'hDEADBEEF;
        int lat; logic [31:0] d; logic [32:0] e;
        issue(1'b0, 32'h40, 5'h1E, wd, lat, d);
        for (int k = 1; k <= 4; k++) begin
            total++;
            if ({tr_wr[k], tr_a[k], tr_d[k]} !== {1'b1, 17'h40 + 17'(k - 1), wd[8*(k-1) +: 8]})
                begin bad++; $display("FAIL store_byte cyc=%0d got=%0b/%h/%h want=1/%h/%h", k, tr_wr[k], tr_a[k], tr_d[k],
                                      17'h40 + 17'(k - 1), wd[8*(k-1) +: 8]); end
        end
        total++; if (lat !== 5) begin bad++; $display("FAIL store_latency got=%0d want=5", lat); end
        total++; if (tr_wr[5] !== 1'b0 || tr_wr[6] !== 1'b0)
            begin bad++; $display("FAIL store_wr_after got=%0b%0b want=00", tr_wr[5], tr_wr[6]); end
        total++; if ({ram[17'h43], ram[17'h42], ram[17'h41], ram[17'h40]} !== wd)
            begin bad++; $display("FAIL store_ram got=%h want=%h", {ram[17'h43], ram[17'h42], ram[17'h41], ram[17'h40]}, wd); end
        issue(1'b0, 32'h50, 5'h16, 32'hCAFE1234, lat, d);
        sb.push_back({1'b0, 32'h00001234});
        issue(1'b0, 32'h50, 5'h14, 32'd0, lat, d);
        e = sb.pop_front();
        total++; if (d !== e[31:0]) begin bad++; $display("FAIL half_store_readback got=%h want=%h", d, e[31:0]); end
    endtask

    task automatic test_wrap();
        int lat; logic [31:0] d; logic [32:0] e;
        ram[17'h1FFFF] = 8'h34; ram[17'h00000] = 8'h12;
        sb.push_back({1'b0, 32'h00001234});
        issue(1'b0, 32'h0003FFFF, 5'h14, 32'd0, lat, d);
        e = sb.pop_front();
        total++; if (tr_a[2] !== 17'd0) begin bad++; $display("FAIL wrap_addr got=%h want=0", tr_a[2]); end
        total++; if (d !== e[31:0]) begin bad++; $display("FAIL wrap_data got=%h want=%h", d, e[31:0]); end
    endtask

    task automatic test_flush();
        int lat; int acks; logic [31:0] d; logic [32:0] e;
        repeat (2) @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        @(posedge clk);
        repeat (2) begin @(posedge clk); #1; end
        bus.if_flush = 1'b1;
        @(posedge clk); #1;
        bus.if_flush = 1'b0; bus.if_req = 1'b0;
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL flush_idle busy got=%0b want=0", bus.busy); end
        acks = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (bus.if_ack) acks++;
        end
        total++; if (acks !== 0) begin bad++; $display("FAIL flush_no_ack got=%0d want=0", acks); end
        ram[17'h104] = 8'h93; ram[17'h105] = 8'h05; ram[17'h106] = 8'h10; ram[17'h107] = 8'h00;
        sb.push_back({1'b1, 32'h00100593});
        issue(1'b1, 32'h104, 5'd0, 32'd0, lat, d);
        e = sb.pop_front();
        total++; if (d !== e[31:0] || lat !== 6)
            begin bad++; $display("FAIL flush_refetch got=%h@%0d want=%h@6", d, lat, e[31:0]); end
    endtask

    task automatic test_reset_mid_write();
        int lat; int acks; logic [31:0] d; logic [32:0] e;
        for (int i = 0; i < 4; i++) ram[17'h60 + 17'(i)] = 8'h00;
        repeat (2) @(negedge clk);
        bus.mem_e = 5'h1E; bus.mem_addr = 32'h60; bus.mem_wdata = 32'h11223344;
        @(posedge clk);
        repeat (3) begin @(posedge clk); #1; end
        rst = 1'b0;
        #1;
        total++;
        if ({bus.busy, bus.ram_wr, bus.ram_a, bus.ram_dout, bus.if_ack, bus.mem_ack} !== '0 ||
            bus.if_data !== 32'd0 || bus.mem_rdata !== 32'd0)
            begin bad++; $display("FAIL midrst_outputs got=%0b%0b/%h/%h/%0b%0b/%h/%h want=all zero", bus.busy, bus.ram_wr,
                                  bus.ram_a, bus.ram_dout, bus.if_ack, bus.mem_ack, bus.if_data, bus.mem_rdata); end
        bus.mem_e = 5'd0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        acks = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (bus.mem_ack) acks++;
        end
        total++; if (acks !== 0) begin bad++; $display("FAIL midrst_no_ack got=%0d want=0", acks); end
        total++; if ({ram[17'h62], ram[17'h61], ram[17'h60]} !== 24'h003344)
            begin bad++; $display("FAIL midrst_partial got=%h want=003344", {ram[17'h62], ram[17'h61], ram[17'h60]}); end
        sb.push_back({1'b0, 32'h00000033});
        issue(1'b0, 32'h61, 5'h10, 32'd0, lat, d);
        e = sb.pop_front();
        total++; if (d !== e[31:0] || lat !== 3)
            begin bad++; $display("FAIL midrst_recover got=%h@%0d want=%h@3", d, lat, e[31:0]); end
    endtask

    task automatic test_collision();
        int n_ack; bit mem_again; bit got_if; logic [31:0] got; logic [32:0] e;
        apply_reset();
        sb.delete();
`ifdef MEM_ARB_RR_EN
        sb.push_back({1'b0, 32'h00000080}); sb.push_back({1'b1, 32'h00A00513}); sb.push_back({1'b0, 32'h000000FF});
`else
        sb.push_back({1'b0, 32'h00000080}); sb.push_back({1'b0, 32'h000000FF}); sb.push_back({1'b1, 32'h00A00513});
`endif
        repeat (2) @(negedge clk);
        bus.if_req = 1'b1; bus.if_addr = 32'h100;
        bus.mem_e = 5'h10; bus.mem_addr = 32'h20;
        n_ack = 0; mem_again = 1'b0;
        for (int k = 0; k < 60 && n_ack < 3; k++) begin
            @(posedge clk); #1;
            if (bus.if_ack || bus.mem_ack) begin
                got_if = bus.if_ack;
                got    = got_if ? bus.if_data : bus.mem_rdata;
                n_ack++;
                total++;
                if (sb.size() == 0) begin
                    bad++; $display("FAIL collide_extra_ack ack=%0d is_if=%0b want=none", n_ack, got_if);
                end else begin
                    e = sb.pop_front();
                    if (got_if !== e[32] || got !== e[31:0])
                        begin bad++; $display("FAIL collide_order ack=%0d got=%0b/%h want=%0b/%h", n_ack, got_if, got, e[32], e[31:0]); end
                end
                if (got_if)          bus.if_req = 1'b0;
                else if (!mem_again) begin bus.mem_addr = 32'h21; mem_again = 1'b1; end
                else                 bus.mem_e = 5'd0;
            end
        end
        bus.if_req = 1'b0; bus.mem_e = 5'd0;
        total++; if (n_ack !== 3) begin bad++; $display("FAIL collide_timeout acks=%0d want=3", n_ack); end
    endtask

    initial begin
        bus.if_req = 1'b0; bus.if_addr = 32'd0; bus.if_flush = 1'b0;
        bus.mem_e = 5'd0; bus.mem_addr = 32'd0; bus.mem_wdata = 32'd0;
        for (int i = 0; i < (1 << 17); i++) ram[i] = 8'h00;
        fork
            forever begin
                @(posedge clk);
                if (bus.ram_wr) ram[bus.ram_a] = bus.ram_dout;
            end
        join_none
        test_reset();
        test_fetch();
        test_loads();
        test_store();
        test_wrap();
        test_flush();
        test_reset_mid_write();
        test_collision();
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end
endmodule
